// File: rtl/matrix_scan_driver.sv
// Scan driver for shift-register LED matrices: pixel memory, PWM line scan and serial output.
// Define MATRIX_DOUBLE_BUFFER_EN for two pixel banks with a frame-aligned swap handshake.
module matrix_scan_driver #(
    parameter int unsigned ROWS       = 16,
    parameter int unsigned COLS       = 16,
    parameter int unsigned DEPTH_BITS = 2,
    parameter int unsigned CLK_DIV    = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [DEPTH_BITS-1:0]   wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic                    serial_clk,
    output logic                    serial_data,
    output logic                    rclk,
    output logic                    clear
);
    localparam int unsigned RowW  = $clog2(ROWS);
    localparam int unsigned NBits = ROWS + COLS;
    localparam int unsigned BitW  = $clog2(NBits + 1);
    localparam int unsigned CntW  = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int unsigned Cells = ROWS * COLS;
`ifdef MATRIX_DOUBLE_BUFFER_EN
    localparam int unsigned Banks = 2;
`else
    localparam int unsigned Banks = 1;
`endif
    localparam int unsigned AddrW = $clog2(Banks * Cells);

    logic [DEPTH_BITS-1:0] mem [Banks*Cells] = '{default: '0};

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  half_q, half_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [RowW-1:0]       row_q, row_d;
    logic [DEPTH_BITS-1:0] phase_q, phase_d;
    logic                  sclk_q, sclk_d, sdata_q, sdata_d, rclk_q, rclk_d;

    logic tick, is_latch, last_row, frame_end, cathode, bit_val, wr_ok;
    logic rd_bank, wr_bank;
    logic [AddrW-1:0]      rd_addr, wr_addr;
    logic [DEPTH_BITS-1:0] pix;

`ifdef MATRIX_DOUBLE_BUFFER_EN
    logic front_q, front_d, pending_q, pending_d, swap_go;
    assign rd_bank  = front_q;
    assign wr_bank  = ~front_q;
    assign swap_go  = frame_end && (pending_q || swap_req);
    assign swap_ack = swap_go && !rst;
`else
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign rd_bank  = 1'b0;
    assign wr_bank  = 1'b0;
    assign swap_ack = 1'b0;
`endif

    // Writes in the swap cycle still use the pre-swap back bank, i.e. the new front.
    assign wr_ok   = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign wr_addr = AddrW'(32'(wr_bank) * Cells + 32'(wr_row) * COLS + 32'(wr_col));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign tick      = cnt_q == CntW'(CLK_DIV);
    assign is_latch  = 32'(bit_q) == NBits;
    assign last_row  = 32'(row_q) == ROWS - 1;
    assign frame_end = tick && half_q && is_latch && last_row && (phase_q == '1);
    assign cathode   = (32'(bit_q) >= ROWS) && !is_latch;
    assign rd_addr   = AddrW'(32'(rd_bank) * Cells + 32'(row_q) * COLS +
                              (cathode ? 32'(bit_q) - ROWS : 0));
    assign pix       = mem[rd_addr];
    assign bit_val   = cathode ? !(pix > phase_q) : (32'(bit_q) == 32'(row_q));

    assign frame_start = !rst && tick && !half_q && (bit_q == '0) && (row_q == '0) &&
                         (phase_q == '0);
    assign clear       = !rst;
    assign serial_clk  = sclk_q;
    assign serial_data = sdata_q;
    assign rclk        = rclk_q;

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CntW'(1);
        half_d  = half_q;
        bit_d   = bit_q;
        row_d   = row_q;
        phase_d = phase_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        rclk_d  = rclk_q;
        if (tick) begin
            half_d = !half_q;
            if (is_latch) begin
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
                rclk_d  = 1'b1;
            end else begin
                sclk_d = half_q;
                rclk_d = 1'b0;
                // Data is set on the first tick only so it holds across the rising edge.
                if (!half_q) begin
                    sdata_d = bit_val;
                end
            end
            if (half_q) begin
                if (!is_latch) begin
                    bit_d = bit_q + BitW'(1);
                end else begin
                    bit_d = '0;
                    if (last_row) begin
                        row_d   = '0;
                        phase_d = phase_q + DEPTH_BITS'(1);
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            row_q   <= '0;
            phase_q <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            rclk_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            rclk_q  <= rclk_d;
        end
    end

`ifdef MATRIX_DOUBLE_BUFFER_EN
    always_comb begin
        front_d   = front_q ^ swap_go;
        pending_d = swap_go ? 1'b0 : (pending_q || swap_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            front_q   <= front_d;
            pending_q <= pending_d;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Randomized bench for matrix_scan_driver: outputs are predicted from the absolute tick count
// since reset release and a behavioural pixel-memory model.
module tb_matrix_scan_driver;
    localparam int R          = 6;
    localparam int C          = 5;
    localparam int D          = 2;
    localparam int CD         = 2;
    localparam int P          = CD + 1;
    localparam int LineTicks  = 2 * (R + C + 1);
    localparam int FrameTicks = LineTicks * (1 << D) * R;
    localparam int FrameClks  = FrameTicks * P;
    localparam int RstAt      = 4 + 2 * FrameClks + 700;
    localparam int TotalCyc   = RstAt + 2 + 3 * FrameClks + 40;
`ifdef MATRIX_DOUBLE_BUFFER_EN
    localparam bit DBuf = 1'b1;
`else
    localparam bit DBuf = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = '0;
    logic [2:0] wr_col = '0;
    logic [1:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic       swap_ack, frame_start, serial_clk, serial_data, rclk, clear;

    int checks = 0;
    int failures = 0;

    // Reference state: pixel banks, displayed bank, pending swap, clk edges since release.
    int   mem [2][R][C];
    int   front = 0;
    int   pending = 0;
    int   n = 0;
    logic e_sclk = 1'b0;
    logic e_sdata = 1'b0;
    logic e_rclk = 1'b0;

    always #5 clk = ~clk;

    matrix_scan_driver #(
        .ROWS       (R),
        .COLS       (C),
        .DEPTH_BITS (D),
        .CLK_DIV    (CD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .serial_clk  (serial_clk),
        .serial_data (serial_data),
        .rclk        (rclk),
        .clear       (clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Tick index (within the frame) that the upcoming edge completes, or -1 if none.
    function automatic int next_tick_pos();
        if ((n + 1) % P != 0) return -1;
        return ((n + 1) / P - 1) % FrameTicks;
    endfunction

    task automatic model_edge();
        int  f, line, row, phase, t, slot, half, wb;
        bit  go;
        if (rst) begin
            n = 0;
            front = 0;
            pending = 0;
            e_sclk = 1'b0;
            e_sdata = 1'b0;
            e_rclk = 1'b0;
            return;
        end
        wb = DBuf ? 1 - front : 0;
        f = next_tick_pos();
        n++;
        go = 1'b0;
        if (f >= 0) begin
            line  = f / LineTicks;
            row   = line % R;
            phase = line / R;
            t     = f % LineTicks;
            slot  = t / 2;
            half  = t % 2;
            if (slot == R + C) begin
                e_sclk = 1'b0;
                e_sdata = 1'b0;
                e_rclk = 1'b1;
            end else begin
                e_sclk = logic'(half);
                e_rclk = 1'b0;
                if (half == 0) begin
                    if (slot < R) e_sdata = (slot == row);
                    else          e_sdata = !(mem[front][row][slot-R] > phase);
                end
            end
            go = DBuf && (f == FrameTicks - 1) && (pending != 0 || swap_req);
        end
        if (go) begin
            front = 1 - front;
            pending = 0;
        end else if (DBuf && swap_req) begin
            pending = 1;
        end
        if (wr_en && wr_row < R && wr_col < C) mem[wb][wr_row][wr_col] = int'(wr_data);
    endtask

    initial begin
        int  pos;
        bit  exp_fs, exp_ack;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) mem[b][r][c] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int cyc = 0; cyc < TotalCyc; cyc++) begin
            rst      = (cyc < 4) || (cyc >= RstAt && cyc < RstAt + 2);
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_row   = 3'($urandom_range(0, 7));
            wr_col   = 3'($urandom_range(0, 7));
            wr_data  = 2'($urandom_range(0, 3));
            swap_req = ($urandom_range(0, 399) == 0) || (cyc == RstAt - 30);
            pos = next_tick_pos();
            if (!rst && pos == FrameTicks - 1) begin
                // Exercise a write landing in the swap cycle.
                swap_req = ($urandom_range(0, 1) == 1);
                wr_en    = 1'b1;
                wr_row   = 3'($urandom_range(0, R - 1));
                wr_col   = 3'($urandom_range(0, C - 1));
            end
            if (rst) begin
                wr_en = 1'b0;
                swap_req = 1'b0;
            end
            #1;
            exp_fs  = !rst && (pos == 0);
            exp_ack = DBuf && !rst && (pos == FrameTicks - 1) && (pending != 0 || swap_req);
            check("clear", clear, !rst);
            check("frame_start", frame_start, exp_fs);
            check("swap_ack", swap_ack, exp_ack);
            check("serial_clk", serial_clk, e_sclk);
            check("serial_data", serial_data, e_sdata);
            check("rclk", rclk, e_rclk);
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
